serial_adder_controller: RTL and testbench
==========================================

SERIAL_ADDER_CONTROLLER -- requirements
Module: serial_adder_controller

Interface
REQ-001 SHALL have parameter Width, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port OperandA, input, Width bits: first addend; latched on accepted Start.
REQ-006 SHALL have port OperandB, input, Width bits: second addend; latched on accepted Start.
REQ-007 SHALL have port CarryIn, input, 1 bit: initial carry; latched on accepted Start.
REQ-008 SHALL have port Busy, output, 1 bit: high while bits are being processed.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port SumOut, output, Width bits: registered sum.
REQ-011 SHALL have port CarryOut, output, 1 bit: registered final carry.

Function
REQ-012 SHALL compute {CarryOut, SumOut} = OperandA + OperandB + CarryIn, with Width+1-bit result and no truncation beyond CarryOut.
REQ-013 SHALL process one bit per cycle, LSB first, through a single shared 1-bit full-adder datapath.
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE transition: Start=1 at a rising edge latches operands and carry into internal registers, clears the bit counter, and moves to RUN; Start=0 stays in IDLE.
REQ-016 RUN behaviour: each cycle adds the operand LSBs and the carry register, shifts the sum bit into the sum register at the MSB (right shift), updates the carry register, and increments the counter.
REQ-017 RUN exit: after exactly Width RUN cycles, SHALL move to DONE.
REQ-018 DONE behaviour: Done=1 for one cycle, then unconditionally return to IDLE.
REQ-019 Timing: with Start accepted at edge k, Busy SHALL be high for cycles k+1..k+Width and Done high in cycle k+Width+1.
REQ-020 Busy SHALL be 1 only in RUN; Done SHALL be 1 only in DONE.
REQ-021 SumOut and CarryOut SHALL be valid when Done=1 and SHALL hold that value until the next accepted Start completes.
REQ-022 SumOut and CarryOut SHALL not show partial results; they update only on the RUN-to-DONE transition.
REQ-023 Start in RUN or DONE SHALL be ignored; operand input changes during RUN SHALL not affect the result.
REQ-024 Start held high continuously SHALL produce back-to-back operations, one result every Width+2 cycles.
REQ-025 The bit counter SHALL be ceil(log2(Width+1)) bits wide and SHALL not wrap within one operation.

Reset
REQ-026 When Reset=1 at a rising edge: state goes to IDLE; Busy=0, Done=0, SumOut=0, CarryOut=0; internal shift, carry and counter registers are cleared.
REQ-027 Reset SHALL take priority over Start and over any in-progress operation; a mid-operation reset discards the partial result.
REQ-028 The first Start after Reset deasserts SHALL be accepted normally.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default Width SHALL live in a shared package/include named serial_adder_pkg.
REQ-030 The 1-bit datapath SHALL be a single instance of sub-module full_adder, itself composed of two half-adder instances plus an OR of their carries; no other arithmetic operator SHALL be used on the datapath.

Verification
REQ-031 Width=8, A=0x5A, B=0x33, CarryIn=0, Start at edge k -> Busy high for k+1..k+8; Done high at k+9 with SumOut=0x8D, CarryOut=0.
REQ-032 A=0xFF, B=0x01, CarryIn=0 -> SumOut=0x00, CarryOut=1.
REQ-033 A=0xFF, B=0xFF, CarryIn=1 -> SumOut=0xFF, CarryOut=1.
REQ-034 Start pulsed with A=0x01, B=0x01 on the 3rd Busy cycle of an operation with A=0x10, B=0x20 -> result is 0x30 only; no extra Done pulse.
REQ-035 Reset asserted on the 4th RUN cycle -> next cycle Busy=0, Done=0, SumOut=0, CarryOut=0; a following Start with A=0x03, B=0x04 yields 0x07.
REQ-036 Start held high with random operands over 100 operations -> Done every 10 cycles, each result matching the reference sum.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: default operand width and the
// controller state encoding.
package serial_adder_pkg;

   localparam int DefaultWidth = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

endpackage

// File: rtl/serial_adder_controller_full_adder.sv
// One-bit full adder built from two half adders; this is the only
// arithmetic element on the serial datapath.

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic carryIn,
   output logic sum,
   output logic carryOut
);
   logic partialSum;
   logic carryFirst;
   logic carrySecond;

   half_adder firstHalf (
      .a     (a),
      .b     (b),
      .sum   (partialSum),
      .carry (carryFirst)
   );

   half_adder secondHalf (
      .a     (partialSum),
      .b     (carryIn),
      .sum   (sum),
      .carry (carrySecond)
   );

   // At most one half adder can generate a carry, so an OR merges them.
   assign carryOut = carryFirst | carrySecond;
endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: adds two Width-bit operands plus a carry-in, one bit per
// cycle, LSB first, through a single full adder.
//
// Handshake: Start is sampled only in IDLE; an accepted Start latches the
// operands and carry-in. Busy is high for exactly Width cycles while bits are
// processed, then Done pulses for one cycle with SumOut/CarryOut valid. The
// result registers hold until the next operation completes. Start seen in
// RUN or DONE is ignored; holding Start high yields one result every
// Width+2 cycles.
module serial_adder_controller
   import serial_adder_pkg::*;
#(
   parameter int Width = DefaultWidth
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [Width-1:0] OperandA,
   input  logic [Width-1:0] OperandB,
   input  logic             CarryIn,
   output logic             Busy,
   output logic             Done,
   output logic [Width-1:0] SumOut,
   output logic             CarryOut,
   output stateT            DebugState
);

   localparam int CntW = $clog2(Width + 1);

   stateT            state;
   stateT            nextState;
   logic             accept;
   logic             lastBit;

   logic [Width-1:0] opA;
   logic [Width-1:0] opB;
   logic             carryReg;
   logic [Width-1:0] sumShift;
   logic [CntW-1:0]  bitCount;

   logic             sumBit;
   logic             carryBit;

   full_adder bitAdder (
      .a        (opA[0]),
      .b        (opB[0]),
      .carryIn  (carryReg),
      .sum      (sumBit),
      .carryOut (carryBit)
   );

   assign DebugState = state;

   // State register; reset returns to IDLE regardless of progress.
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state and control decode; the last RUN cycle is when the counter
   // has already seen Width-1 bits.
   always_comb begin
      nextState = state;
      Busy      = 1'b0;
      Done      = 1'b0;
      accept    = 1'b0;
      lastBit   = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            Busy = 1'b1;
            if (bitCount == CntW'(Width - 1)) begin
               lastBit   = 1'b1;
               nextState = DONE;
            end
         end
         DONE: begin
            Done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Operand/carry/sum shift registers and bit counter; the visible result
   // is written only on the final RUN cycle so partial sums never show.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         opA      <= '0;
         opB      <= '0;
         carryReg <= 1'b0;
         sumShift <= '0;
         bitCount <= '0;
         SumOut   <= '0;
         CarryOut <= 1'b0;
      end else if (accept) begin
         opA      <= OperandA;
         opB      <= OperandB;
         carryReg <= CarryIn;
         sumShift <= '0;
         bitCount <= '0;
      end else if (Busy) begin
         opA      <= {1'b0, opA[Width-1:1]};
         opB      <= {1'b0, opB[Width-1:1]};
         carryReg <= carryBit;
         sumShift <= {sumBit, sumShift[Width-1:1]};
         bitCount <= bitCount + CntW'(1);
         if (lastBit) begin
            SumOut   <= {sumBit, sumShift[Width-1:1]};
            CarryOut <= carryBit;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Bench for serial_adder_controller at Width=8: directed vector table,
// mid-run Start and Reset sequences, and back-to-back random operations
// checked against an arithmetic reference.
module tb_serial_adder_controller;
   import serial_adder_pkg::*;

   localparam int W = 8;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         Start;
   logic [W-1:0] OperandA;
   logic [W-1:0] OperandB;
   logic         CarryIn;
   logic         Busy;
   logic         Done;
   logic [W-1:0] SumOut;
   logic         CarryOut;
   stateT        debugState;

   int checks   = 0;
   int failures = 0;

   serial_adder_controller #(.Width(W)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start      (Start),
      .OperandA   (OperandA),
      .OperandB   (OperandB),
      .CarryIn    (CarryIn),
      .Busy       (Busy),
      .Done       (Done),
      .SumOut     (SumOut),
      .CarryOut   (CarryOut),
      .DebugState (debugState)
   );

   // Clock generation.
   always #5 Clock = ~Clock;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] expSum;
      logic         expCarry;
   } vecT;

   vecT vecs[7];
   logic [W:0] expQ[$];

   function automatic logic [W:0] refSum(logic [W-1:0] a, logic [W-1:0] b, logic cin);
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Runs one operation from IDLE. Samples on negedges: cycle n=1 is the
   // first cycle after the accepting edge. Operands are scrambled during RUN;
   // glitchAt (1..8) pulses Start with 0x01/0x01 in that Busy cycle.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] expSum, input logic expCarry,
                        input int glitchAt, input string tag);
      logic         timingOk;
      logic [W-1:0] sumAtDone;
      logic         carryAtDone;
      timingOk    = 1'b1;
      sumAtDone   = '0;
      carryAtDone = 1'b0;
      @(negedge Clock);
      Start = 1'b1; OperandA = a; OperandB = b; CarryIn = cin;
      for (int n = 1; n <= 12; n++) begin
         @(negedge Clock);
         if (Busy !== (n <= W) || Done !== (n == W + 1)) timingOk = 1'b0;
         if (n == W + 1) begin
            sumAtDone   = SumOut;
            carryAtDone = CarryOut;
         end
         OperandA = W'($urandom);
         OperandB = W'($urandom);
         CarryIn  = 1'($urandom);
         if (n == glitchAt) begin
            Start = 1'b1; OperandA = 8'h01; OperandB = 8'h01; CarryIn = 1'b0;
         end else begin
            Start = 1'b0;
         end
      end
      check({tag, "_timing"}, 32'(timingOk), 32'd1);
      check({tag, "_sum"},    32'(sumAtDone), 32'(expSum));
      check({tag, "_carry"},  32'(carryAtDone), 32'(expCarry));
      check({tag, "_hold"},   32'({CarryOut, SumOut}), 32'({expCarry, expSum}));
   endtask

   initial begin
      int           doneCount;
      int           cyc;
      int           lastDone;
      logic         periodOk;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   expv;

      vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
      vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      // Reset, with Start asserted to show reset wins.
      Reset = 1'b1; Start = 1'b1;
      OperandA = 8'hC3; OperandB = 8'h3C; CarryIn = 1'b1;
      repeat (3) @(negedge Clock);
      check("rst_busy",  32'(Busy), 32'd0);
      check("rst_done",  32'(Done), 32'd0);
      check("rst_sum",   32'(SumOut), 32'd0);
      check("rst_carry", 32'(CarryOut), 32'd0);
      check("rst_state", 32'(debugState), 32'(IDLE));
      Reset = 1'b0; Start = 1'b0;

      // Directed table.
      for (int i = 0; i < 7; i++)
         runOp(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].expSum, vecs[i].expCarry,
               0, $sformatf("vec%0d", i));

      // Start pulsed in the 3rd Busy cycle is ignored.
      runOp(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "midstart");

      // Reset on the 4th RUN cycle discards the operation and clears results.
      @(negedge Clock);
      Start = 1'b1; OperandA = 8'h9C; OperandB = 8'h21; CarryIn = 1'b0;
      @(negedge Clock);
      Start = 1'b0;
      repeat (3) @(negedge Clock);
      check("midrst_busy_before", 32'(Busy), 32'd1);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check("midrst_busy",  32'(Busy), 32'd0);
      check("midrst_done",  32'(Done), 32'd0);
      check("midrst_sum",   32'(SumOut), 32'd0);
      check("midrst_carry", 32'(CarryOut), 32'd0);
      runOp(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 0, "afterrst");

      // Back-to-back random operations with Start held high.
      @(negedge Clock);
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      OperandA = ra; OperandB = rb; CarryIn = rc; Start = 1'b1;
      expQ.push_back(refSum(ra, rb, rc));
      doneCount = 0; cyc = 0; lastDone = -1; periodOk = 1'b1;
      while (doneCount < 100 && cyc < 1500) begin
         @(negedge Clock);
         cyc++;
         if (Done === 1'b1) begin
            expv = (expQ.size() > 0) ? expQ.pop_front() : '0;
            check("b2b_result", 32'({CarryOut, SumOut}), 32'(expv));
            if (lastDone >= 0 && cyc - lastDone != W + 2) periodOk = 1'b0;
            lastDone = cyc;
            doneCount++;
            if (doneCount < 100) begin
               ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
               OperandA = ra; OperandB = rb; CarryIn = rc;
               expQ.push_back(refSum(ra, rb, rc));
            end else begin
               Start = 1'b0;
            end
         end
      end
      check("b2b_count",  32'(doneCount), 32'd100);
      check("b2b_period", 32'(periodOk), 32'd1);
      repeat (4) @(negedge Clock);
      check("final_idle", 32'(debugState), 32'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
